udp_payload_buffer: RTL and testbench
=====================================

# udp_payload_buffer

Buffers one outgoing UDP payload, arriving as an N-bit-per-cycle stream, and computes its byte length and 16-bit one's-complement sum. It then holds those two values stable for the UDP transmit stage and replays the stored payload on request. It sits directly upstream of the transport/UDP transmit stage and drives that stage's `data_length_in` and `data_checksum_in`. Its replay stream is muxed in after the transmitted headers.

## Interface
- `N`, default 2: stream chunk width in bits; must divide 8.
- `DEPTH_BYTES`, default 1472: payload storage capacity in bytes; the address width is `$clog2(DEPTH_BYTES)`.

- `clk`  input  1  system clock
- `rst`  input  1  reset, synchronous, active-high
- `axiiv`  input  1  input chunk valid
- `axiid`  input  N  input chunk
- `axii_last`  input  1  final chunk of the payload (qualified by `axiiv`)
- `replay_start`  input  1  single-cycle pulse requesting replay; honoured only in READY
- `meta_valid`  output  1  length and checksum are valid; held through READY and REPLAY
- `data_length_out`  output  16  payload byte count, excluding the 8-byte UDP header
- `data_checksum_out`  output  16  folded one's-complement sum of the payload, not inverted
- `overflow`  output  1  one-cycle pulse when a frame is dropped for exceeding capacity
- `axiov`  output  1  replay chunk valid
- `axiod`  output  N  replay chunk
- `axi_last`  output  1  final replay chunk

## Operation
- **Chunk order:** chunks within a byte arrive least-significant first, in Ethernet order. Replay uses the same order.
- **Checksum words:** bytes pair into big-endian 16-bit words; the even-index byte is the high byte. An odd final byte is padded with 0x00 in the low half.
- **Accumulator:** 17-bit; the carry is folded back in on every word add. A final fold happens before `meta_valid` asserts.
- **FSM states:**
  - **FILL:** reset state. Accepts chunks, writes completed bytes to storage, increments the byte count and updates the sum.
  - **FILL -> FINISH:** on `axiiv && axii_last`. A partial byte (fewer than 8/N chunks) at `axii_last` is discarded and not counted.
  - **FINISH:** adds any pending odd byte, then does the final fold. Lasts 1 cycle, then goes to READY.
  - **READY:** `meta_valid`=1. Goes to REPLAY on `replay_start`.
  - **REPLAY:** streams stored bytes. After the last chunk it goes to FILL, and the count, sum and `meta_valid` clear.
- **Input while not in FILL:** ignored and dropped silently.
- **Overflow:** a byte arriving when the count already equals DEPTH_BYTES pulses `overflow` and discards the frame. The block stays in FILL with count and sum cleared, and ignores chunks until the next `axii_last`; that chunk is also ignored.
- **Zero-byte frame:** `axii_last` with no complete byte goes to READY with length 0 and sum 0. Replay then produces no `axiov` and returns to FILL in 1 cycle.
- **Simultaneous `rst` and any other event:** `rst` wins.

## Timing
- **Reset values:** state FILL; `meta_valid`, `overflow`, `axiov`, `axi_last` = 0; `axiod`, `data_length_out`, `data_checksum_out` = 0.
- **Input throughput:** one chunk per cycle, no backpressure. Gaps in `axiiv` are allowed.
- **Metadata latency:** `meta_valid` rises 2 cycles after the cycle carrying `axii_last`.
- **Replay latency:** first `axiov` is 2 cycles after the `replay_start` cycle, to cover the registered storage read.
- **Replay stream:** `axiov` stays high continuously for 8·len/N cycles. `axi_last` is high with the final chunk only.
- **Output stability:** `data_length_out` and `data_checksum_out` are stable from `meta_valid` rise until the cycle after `axi_last`.
- **`replay_start` outside READY:** ignored.

## Configuration
- **`UDP_PAYLOAD_MIN_PAD_EN` defined:** payloads shorter than 18 bytes are zero-padded to 18 bytes, which gives a 64-byte minimum Ethernet frame.
  - `data_length_out` reports 18; the checksum is unchanged, since zero adds nothing.
  - Replay emits the pad chunks as 0.
  - A zero-byte frame replays 18 zero bytes.
- **Undefined:** no padding; length and replay are exactly the received bytes.

## Test plan
- **Even-length payload:** bytes 0x45,0x00,0x00,0x1C as dibits LSB-first, `axii_last` on the 16th chunk.
  - Expect length 4 and checksum 0x451C.
  - Expect `meta_valid` 2 cycles after last.
  - Expect replay of 16 identical dibits starting 2 cycles after `replay_start`, with `axi_last` on the 16th.
- **Odd length with carry:** bytes 0xFF,0xFF,0x00,0x01,0x80 -> length 5; sum 0xFFFF+0x0001=0x0001 after fold, +0x8000 gives checksum 0x8001.
- **Overflow:** with DEPTH_BYTES=4, send 5 bytes.
  - Expect an `overflow` pulse on byte 5 and no `meta_valid`.
  - A following 2-byte frame 0x12,0x34 reports length 2 and checksum 0x1234.
- **Input during READY/REPLAY is dropped:** the next frame's length and checksum are unaffected. A partial byte at `axii_last` is not counted.
- **Reset mid-REPLAY:** all outputs go to 0 the next cycle, and the next frame behaves normally.
- **With `UDP_PAYLOAD_MIN_PAD_EN`:** a 2-byte payload 0xAB,0xCD reports length 18 and checksum 0xABCD. Replay runs 72 chunks; the last 64 are zero.

Source files
------------

// File: rtl/udp_payload_buffer.sv
// Stores one UDP payload stream, reports its byte length and folded one's-complement sum, then replays it.
// Optional build macro UDP_PAYLOAD_MIN_PAD_EN pads short payloads to 18 bytes.
//
// state      | meaning
// S_FILL     | collecting chunks into storage, counting bytes, summing words
// S_FINISH   | adding pending odd byte, latching length and checksum
// S_READY    | metadata valid, waiting for replay_start
// S_REPLAY   | streaming stored bytes out
module udp_payload_buffer #(
    parameter int N           = 2,
    parameter int DEPTH_BYTES = 1472
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         axiiv,
    input  logic [N-1:0] axiid,
    input  logic         axii_last,
    input  logic         replay_start,
    output logic         meta_valid,
    output logic [15:0]  data_length_out,
    output logic [15:0]  data_checksum_out,
    output logic         overflow,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic         axi_last
);
    localparam int CPB = 8 / N;
    localparam int CIW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(DEPTH_BYTES);
    localparam int CW  = $clog2(DEPTH_BYTES + 1);
`ifdef UDP_PAYLOAD_MIN_PAD_EN
    localparam logic [15:0] MIN_LEN = 16'd18;
`else
    localparam logic [15:0] MIN_LEN = 16'd0;
`endif

    typedef enum logic [1:0] {S_FILL, S_FINISH, S_READY, S_REPLAY} state_t;

    state_t         state_q, state_d;
    logic [CIW-1:0] ci_q;
    logic [7:0]     byte_sr_q, byte_now;
    logic [CW-1:0]  count_q;
    logic [15:0]    sum_q;
    logic [7:0]     hi_q;
    logic           discard_q;
    logic [15:0]    len_q, csum_q;
    logic           overflow_q;
    logic [15:0]    rbyte_q;
    logic [CIW-1:0] rchunk_q;
    logic [7:0]     mem [DEPTH_BYTES];
    logic [7:0]     rd_byte_q;
    logic           v1_q, zero1_q, last1_q;
    logic [CIW-1:0] sel1_q;

    logic           byte_done, full, wr_en, issuing, replay_done;
    logic [15:0]    len_final, csum_final;

    function automatic logic [15:0] fold_add(input logic [15:0] a, input logic [15:0] w);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, w};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    always_comb begin
        byte_now = byte_sr_q;
        byte_now[ci_q*N +: N] = axiid;
    end

    assign byte_done   = (state_q == S_FILL) && axiiv && !discard_q && (ci_q == CIW'(CPB - 1));
    assign full        = (count_q == CW'(DEPTH_BYTES));
    assign wr_en       = byte_done && !full;
    assign issuing     = (state_q == S_REPLAY) && (rbyte_q != len_q);
    assign replay_done = (state_q == S_REPLAY) && ((len_q == 16'd0) || (v1_q && last1_q));
    assign len_final   = (16'(count_q) < MIN_LEN) ? MIN_LEN : 16'(count_q);
    assign csum_final  = count_q[0] ? fold_add(sum_q, {hi_q, 8'h00}) : sum_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:   if (axiiv && axii_last && !discard_q && !(byte_done && full)) state_d = S_FINISH;
            S_FINISH: state_d = S_READY;
            S_READY:  if (replay_start) state_d = S_REPLAY;
            S_REPLAY: if (replay_done) state_d = S_FILL;
            default:  state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ci_q       <= '0;
            byte_sr_q  <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            hi_q       <= '0;
            discard_q  <= 1'b0;
            len_q      <= '0;
            csum_q     <= '0;
            overflow_q <= 1'b0;
            rbyte_q    <= '0;
            rchunk_q   <= '0;
            v1_q       <= 1'b0;
            zero1_q    <= 1'b0;
            last1_q    <= 1'b0;
            sel1_q     <= '0;
        end else begin
            overflow_q <= 1'b0;
            if (state_q == S_FILL && axiiv) begin
                if (discard_q) begin
                    if (axii_last) discard_q <= 1'b0;
                end else begin
                    // a partial byte at axii_last is dropped by restarting the chunk index
                    if (ci_q == CIW'(CPB - 1) || axii_last) ci_q <= '0;
                    else                                    ci_q <= ci_q + CIW'(1);
                    byte_sr_q <= byte_now;
                    if (byte_done) begin
                        if (full) begin
                            overflow_q <= 1'b1;
                            count_q    <= '0;
                            sum_q      <= '0;
                            discard_q  <= !axii_last;
                        end else begin
                            count_q <= count_q + CW'(1);
                            if (!count_q[0]) hi_q  <= byte_now;
                            else             sum_q <= fold_add(sum_q, {hi_q, byte_now});
                        end
                    end
                end
            end
            if (state_q == S_FINISH) begin
                len_q  <= len_final;
                csum_q <= csum_final;
            end
            // read pipeline: address issued this cycle, byte and chunk select presented next cycle
            v1_q    <= issuing;
            sel1_q  <= rchunk_q;
            zero1_q <= (rbyte_q >= 16'(count_q));
            last1_q <= (rbyte_q == len_q - 16'd1) && (rchunk_q == CIW'(CPB - 1));
            if (state_q != S_REPLAY) begin
                rbyte_q  <= '0;
                rchunk_q <= '0;
            end else if (issuing) begin
                if (rchunk_q == CIW'(CPB - 1)) begin
                    rchunk_q <= '0;
                    rbyte_q  <= rbyte_q + 16'd1;
                end else begin
                    rchunk_q <= rchunk_q + CIW'(1);
                end
            end
            if (replay_done) begin
                len_q   <= '0;
                csum_q  <= '0;
                count_q <= '0;
                sum_q   <= '0;
                hi_q    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= byte_now;
        rd_byte_q <= mem[rbyte_q[AW-1:0]];
    end

    always_comb begin
        axiod = '0;
        if (v1_q && !zero1_q) axiod = rd_byte_q[sel1_q*N +: N];
    end

    assign axiov             = v1_q;
    assign axi_last          = v1_q && last1_q;
    assign meta_valid        = (state_q == S_READY) || (state_q == S_REPLAY);
    assign data_length_out   = len_q;
    assign data_checksum_out = csum_q;
    assign overflow          = overflow_q;
endmodule

// File: tb/tb_udp_payload_buffer.sv
// Directed bench for udp_payload_buffer with N=2 and an 8-byte store.
module tb_udp_payload_buffer;
    logic        clk = 1'b0;
    logic        rst, axiiv, axii_last, replay_start;
    logic [1:0]  axiid;
    logic        meta_valid, overflow, axiov, axi_last;
    logic [15:0] data_length_out, data_checksum_out;
    logic [1:0]  axiod;

    int errors = 0;
    int checks = 0;

`ifdef UDP_PAYLOAD_MIN_PAD_EN
    localparam int MINL = 18;
`else
    localparam int MINL = 0;
`endif

    udp_payload_buffer #(.N(2), .DEPTH_BYTES(8)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axii_last(axii_last),
        .replay_start(replay_start), .meta_valid(meta_valid),
        .data_length_out(data_length_out), .data_checksum_out(data_checksum_out),
        .overflow(overflow), .axiov(axiov), .axiod(axiod), .axi_last(axi_last)
    );

    always #5 clk = ~clk;

    function automatic int exp_len(input int n);
        return (n < MINL) ? MINL : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        for (int i = 0; i < 4; i++) begin
            axiiv     = 1'b1;
            axiid     = b[2*i +: 2];
            axii_last = last && (i == 3);
            step();
        end
        axiiv     = 1'b0;
        axii_last = 1'b0;
    endtask

    task automatic meta_check(input string tag, input int len, input logic [15:0] sum);
        step();
        chk({tag, "_meta"}, meta_valid, 1);
        chk({tag, "_len"}, data_length_out, len);
        chk({tag, "_csum"}, data_checksum_out, sum);
    endtask

    task automatic do_replay(input string tag, input int exp_n);
        int n;
        bit done;
        n = 0;
        done = 0;
        replay_start = 1'b1;
        step();
        replay_start = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (axiov) n++;
            if (axi_last || (exp_n == 0 && c >= 2)) done = 1;
            step();
        end
        chk({tag, "_replay_done"}, done, 1);
        chk({tag, "_replay_chunks"}, n, exp_n);
        chk({tag, "_meta_clear"}, meta_valid, 0);
    endtask

    initial begin
        logic [7:0] f1 [4];
        logic [7:0] tb_b;
        logic [1:0] exp_d;
        int nch;
        f1 = '{8'h45, 8'h00, 8'h00, 8'h1C};
        rst = 1'b1; axiiv = 1'b0; axiid = '0; axii_last = 1'b0; replay_start = 1'b0;
        step(); step();
        chk("rst_meta", meta_valid, 0);
        chk("rst_len", data_length_out, 0);
        chk("rst_csum", data_checksum_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_axiov", axiov, 0);
        chk("rst_last", axi_last, 0);
        chk("rst_axiod", axiod, 0);
        rst = 1'b0;
        step();

        // replay_start in FILL must be ignored
        replay_start = 1'b1; step(); replay_start = 1'b0;
        step(); step();
        chk("fill_replay_axiov", axiov, 0);
        chk("fill_replay_meta", meta_valid, 0);

        // even-length frame with detailed replay timing
        for (int i = 0; i < 4; i++) send_byte(f1[i], i == 3);
        chk("f1_meta_early", meta_valid, 0);
        meta_check("f1", exp_len(4), 16'h451C);
        replay_start = 1'b1; step(); replay_start = 1'b0;
        chk("f1_lat1_axiov", axiov, 0);
        step();
        nch = exp_len(4) * 4;
        for (int i = 0; i < nch; i++) begin
            if (i < 16) begin
                tb_b  = f1[i / 4];
                exp_d = tb_b[2*(i % 4) +: 2];
            end else begin
                exp_d = 2'b00;
            end
            chk("f1_axiov", axiov, 1);
            chk("f1_axiod", axiod, exp_d);
            chk("f1_axi_last", axi_last, (i == nch - 1) ? 1 : 0);
            if (i == nch - 1) chk("f1_len_hold", data_length_out, exp_len(4));
            step();
        end
        chk("f1_after_axiov", axiov, 0);
        chk("f1_after_meta", meta_valid, 0);
        chk("f1_after_len", data_length_out, 0);

        // odd length with end-around carry, input during READY dropped
        send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h80, 1);
        meta_check("f2", exp_len(5), 16'h8001);
        send_byte(8'h55, 1);
        chk("f2_ready_len", data_length_out, exp_len(5));
        chk("f2_ready_csum", data_checksum_out, 16'h8001);
        do_replay("f2", exp_len(5) * 4);

        // trailing partial byte at axii_last not counted
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        axiiv = 1'b1; axiid = 2'b11; step();
        axii_last = 1'b1; step();
        axiiv = 1'b0; axii_last = 1'b0;
        meta_check("f3", exp_len(2), 16'h1234);
        do_replay("f3", exp_len(2) * 4);

        // full store, no overflow
        for (int b = 1; b <= 8; b++) send_byte(8'(b), b == 8);
        chk("f4_ovf", overflow, 0);
        meta_check("f4", exp_len(8), 16'h1014);
        do_replay("f4", exp_len(8) * 4);

        // overflow on the ninth byte, rest of frame discarded
        for (int b = 1; b <= 8; b++) send_byte(8'(b), 0);
        chk("ovf_before", overflow, 0);
        send_byte(8'h09, 0);
        chk("ovf_pulse", overflow, 1);
        step();
        chk("ovf_pulse_end", overflow, 0);
        send_byte(8'h0A, 1);
        step(); step();
        chk("ovf_no_meta", meta_valid, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 1);
        meta_check("f5", exp_len(2), 16'h1234);
        do_replay("f5", exp_len(2) * 4);

        // zero-byte frame
        axiiv = 1'b1; axiid = 2'b11; axii_last = 1'b1; step();
        axiiv = 1'b0; axii_last = 1'b0;
        meta_check("f6", exp_len(0), 16'h0000);
        do_replay("f6", exp_len(0) * 4);

        // reset in the middle of replay
        send_byte(8'hAB, 0); send_byte(8'hCD, 1);
        meta_check("f7", exp_len(2), 16'hABCD);
        replay_start = 1'b1; step(); replay_start = 1'b0;
        step(); step(); step();
        chk("f7_mid_axiov", axiov, 1);
        rst = 1'b1; step();
        chk("f7_rst_axiov", axiov, 0);
        chk("f7_rst_axiod", axiod, 0);
        chk("f7_rst_last", axi_last, 0);
        chk("f7_rst_meta", meta_valid, 0);
        chk("f7_rst_len", data_length_out, 0);
        chk("f7_rst_csum", data_checksum_out, 0);
        rst = 1'b0;
        step();
        send_byte(8'h12, 0); send_byte(8'h34, 1);
        meta_check("f8", exp_len(2), 16'h1234);
        do_replay("f8", exp_len(2) * 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
